// File: rtl/alu_md.sv
// alu_md: handshaked rv32i execute unit with the ten base ALU ops (single cycle)
// and the RV32M multiply/divide group on an iterative XLEN-step datapath.
module alu_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [2:0]        mop;
    logic              neg_res, div_zero;
    logic [XLEN-1:0]   acc_hi, acc_lo, opnd, orig_a;

    logic              is_base, is_mop, accept, last_step;
    logic [XLEN-1:0]   base_res;
    logic              a_signed, b_signed, a_neg, b_neg, start_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   addend, sub_lo, step_hi, step_lo;
    logic [XLEN:0]     sum, rem_shift;
    logic              ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, m_res;

    assign is_base   = (op < 5'd10);
    assign is_mop    = (op[4:3] == 2'b10);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign last_step = (state == CALC) && (count == CW'(1));

    always_comb begin
        base_res = '0;
        case (op)
            5'h00:   base_res = data1 + data2;
            5'h01:   base_res = data1 - data2;
            5'h02:   base_res = data1 << data2[SHW-1:0];
            5'h03:   base_res = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
            5'h04:   base_res = {{(XLEN-1){1'b0}}, (data1 < data2)};
            5'h05:   base_res = data1 ^ data2;
            5'h06:   base_res = data1 >> data2[SHW-1:0];
            5'h07:   base_res = $unsigned($signed(data1) >>> data2[SHW-1:0]);
            5'h08:   base_res = data1 | data2;
            5'h09:   base_res = data1 & data2;
            default: base_res = '0;
        endcase
    end

    // M ops run on magnitudes; the sign of the final value is decided at accept time.
    always_comb begin
        a_signed  = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        b_signed  = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        a_neg     = a_signed && data1[XLEN-1];
        b_neg     = b_signed && data2[XLEN-1];
        mag_a     = a_neg ? (-data1) : data1;
        mag_b     = b_neg ? (-data2) : data2;
        start_neg = (op[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        addend    = acc_lo[0] ? opnd : '0;
        sum       = {1'b0, acc_hi} + {1'b0, addend};
        rem_shift = {acc_hi, acc_lo[XLEN-1]};
        ge        = (rem_shift >= {1'b0, opnd});
        sub_lo    = rem_shift[XLEN-1:0] - opnd;
        if (!mop[2]) begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], acc_lo[XLEN-1:1]};
        end else begin
            step_hi = ge ? sub_lo : rem_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], ge};
        end
    end

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_res ? (-prod) : prod;
        quo_fix  = neg_res ? (-step_lo) : step_lo;
        rem_fix  = neg_res ? (-step_hi) : step_hi;
        case (mop)
            3'd0:               m_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:   m_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:         m_res = div_zero ? '1 : quo_fix;
            default:            m_res = div_zero ? orig_a : rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)                      state_next = IDLE;
        else if (state == IDLE && accept && is_mop) state_next = CALC;
        else if (last_step)             state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            mop      <= '0;
            neg_res  <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            orig_a   <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept && is_mop) begin
            count    <= CW'(XLEN);
            mop      <= op[2:0];
            neg_res  <= start_neg;
            div_zero <= (data2 == '0);
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            opnd     <= mag_b;
            orig_a   <= data1;
        end else if (state == CALC) begin
            count  <= count - CW'(1);
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // Single-entry output register; a reload in the draining cycle wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (accept && !is_mop) begin
            out_valid <= 1'b1;
            result    <= base_res;
            zero      <= is_base && (base_res == '0);
            err       <= !is_base;
        end else if (last_step) begin
            out_valid <= 1'b1;
            result    <= m_res;
            zero      <= (m_res == '0);
            err       <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md; a reference model predicts every accepted
// request and the monitor compares each delivered result, plus directed latency/flush/reset checks.
module tb_alu_md;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        err;

    int   checkCount = 0;
    int   errorCount = 0;
    exp_t sbQueue[$];
    logic prevStall = 1'b0;
    logic [31:0] heldRes;
    logic heldZero, heldErr;
    logic streamDone;

    logic [4:0] opPool [20] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                                5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h0A, 5'h1F};

    alu_md dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model written from the ISA definition using wide native arithmetic.
    function automatic exp_t refModel(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        e.res = '0;
        e.err = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            5'h00: e.res = a + b;
            5'h01: e.res = a - b;
            5'h02: e.res = a << b[4:0];
            5'h03: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h04: e.res = (a < b) ? 32'd1 : 32'd0;
            5'h05: e.res = a ^ b;
            5'h06: e.res = a >> b[4:0];
            5'h07: e.res = $unsigned($signed(a) >>> b[4:0]);
            5'h08: e.res = a | b;
            5'h09: e.res = a & b;
            5'h10: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; end
            5'h11: begin p = sa * sb; e.res = p[63:32]; end
            5'h12: begin p = sa * ub; e.res = p[63:32]; end
            5'h13: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
            5'h14: begin
                if (b == 32'd0) e.res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
                else e.res = ia / ib;
            end
            5'h15: e.res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 32'd0) e.res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'd0;
                else e.res = ia % ib;
            end
            5'h17: e.res = (b == 32'd0) ? a : a % b;
            default: e.err = 1'b1;
        endcase
        e.zero = !e.err && (e.res == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: pop before push so drain-and-accept cycles line up.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbQueue.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_valid", {63'b0, out_valid}, 64'd1);
                checkOutput("hold_res", {32'b0, result}, {32'b0, heldRes});
                checkOutput("hold_flags", {62'b0, zero, err}, {62'b0, heldZero, heldErr});
            end
            if (out_valid && !out_ready)
                checkOutput("stall_ready", {63'b0, in_ready}, 64'd0);
            if (flush) begin
                sbQueue.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("sb_extra", 64'(sbQueue.size()), 64'd1);
                    end else begin
                        exp_t e;
                        e = sbQueue.pop_front();
                        checkOutput("sb_res", {32'b0, result}, {32'b0, e.res});
                        checkOutput("sb_flags", {62'b0, zero, err}, {62'b0, e.zero, e.err});
                    end
                end
                if (in_valid && in_ready)
                    sbQueue.push_back(refModel(op, data1, data2));
            end
            prevStall = out_valid && !out_ready && !flush;
            heldRes   = result;
            heldZero  = zero;
            heldErr   = err;
        end
    end

    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        in_valid = 1'b1;
        op       = o;
        data1    = a;
        data2    = b;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("accept_timeout", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data1    = $urandom;
        data2    = $urandom;
    endtask

    task automatic checkResult(input string tag, input int expWait, input logic [31:0] expRes,
                               input logic expZero, input logic expErr);
        int g = 0;
        int busy = 0;
        @(negedge clk);
        while (!out_valid && g < expWait + 8) begin
            if (!in_ready) busy++;
            g++;
            @(negedge clk);
        end
        checkOutput({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
        checkOutput({tag, "_latency"}, 64'(g), 64'(expWait));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(expWait));
        checkOutput({tag, "_res"}, {32'b0, result}, {32'b0, expRes});
        checkOutput({tag, "_zero"}, {63'b0, zero}, {63'b0, expZero});
        checkOutput({tag, "_err"}, {63'b0, err}, {63'b0, expErr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 5'h00;
        data1     = '0;
        data2     = '0;
        out_ready = 1'b1;
        streamDone = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_res", {32'b0, result}, 64'd0);
        checkOutput("rst_flags", {62'b0, zero, err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] base group");
        applyStimulus(5'h00, 32'h7FFF_FFFF, 32'd1);  checkResult("add_wrap", 0, 32'h8000_0000, 1'b0, 1'b0);
        applyStimulus(5'h01, 32'd5, 32'd5);          checkResult("sub_zero", 0, 32'd0, 1'b1, 1'b0);
        applyStimulus(5'h07, 32'h8000_0000, 32'h24); checkResult("sra", 0, 32'hF800_0000, 1'b0, 1'b0);
        applyStimulus(5'h03, 32'hFFFF_FFFF, 32'd1);  checkResult("slt", 0, 32'd1, 1'b0, 1'b0);
        applyStimulus(5'h04, 32'hFFFF_FFFF, 32'd1);  checkResult("sltu", 0, 32'd0, 1'b1, 1'b0);
        applyStimulus(5'h0A, 32'd3, 32'd4);          checkResult("illegal_0a", 0, 32'd0, 1'b0, 1'b1);
        applyStimulus(5'h1F, 32'd0, 32'd0);          checkResult("illegal_1f", 0, 32'd0, 1'b0, 1'b1);

        $display("[TB] M group");
        applyStimulus(5'h11, 32'h8000_0000, 32'h8000_0000); checkResult("mulh", 32, 32'h4000_0000, 1'b0, 1'b0);
        applyStimulus(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF); checkResult("mulhu", 32, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF); checkResult("mulhsu", 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(5'h10, 32'hFFFF_FFFF, 32'd3);         checkResult("mul", 32, 32'hFFFF_FFFD, 1'b0, 1'b0);
        applyStimulus(5'h14, 32'd7, 32'd0);                 checkResult("div_by0", 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(5'h16, 32'd7, 32'd0);                 checkResult("rem_by0", 32, 32'd7, 1'b0, 1'b0);
        applyStimulus(5'h14, 32'h8000_0000, 32'hFFFF_FFFF); checkResult("div_ovf", 32, 32'h8000_0000, 1'b0, 1'b0);
        applyStimulus(5'h16, 32'h8000_0000, 32'hFFFF_FFFF); checkResult("rem_ovf", 32, 32'd0, 1'b1, 1'b0);
        applyStimulus(5'h14, 32'hFFFF_FFF9, 32'd2);         checkResult("div_neg", 32, 32'hFFFF_FFFD, 1'b0, 1'b0);
        applyStimulus(5'h16, 32'hFFFF_FFF9, 32'd2);         checkResult("rem_neg", 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(5'h15, 32'd100, 32'd7);               checkResult("divu", 32, 32'd14, 1'b0, 1'b0);
        applyStimulus(5'h17, 32'd100, 32'd7);               checkResult("remu", 32, 32'd2, 1'b0, 1'b0);

        $display("[TB] back-to-back stream with out_ready toggling");
        streamDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(5'h00, $urandom, $urandom);
                streamDone = 1'b1;
            end
            begin
                while (!streamDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] random mix with backpressure");
        streamDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    applyStimulus(opPool[$urandom_range(0, 19)], pickOperand(), pickOperand());
                streamDone = 1'b1;
            end
            begin
                while (!streamDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("[TB] flush during DIVU");
        applyStimulus(5'h15, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_ready_low", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("flush_ready_back", {63'b0, in_ready}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("flush_discard", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset during DIVU");
        applyStimulus(5'h15, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("arst_res", {32'b0, result}, 64'd0);
        checkOutput("arst_flags", {62'b0, zero, err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_ready", {63'b0, in_ready}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("arst_no_partial", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(5'h00, 32'd2, 32'd3);
        checkResult("post_rst_add", 0, 32'd5, 1'b0, 1'b0);

        $display("[TB] flush with pending result and with in_valid");
        out_ready = 1'b0;
        applyStimulus(5'h00, 32'd1, 32'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_drop", {63'b0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = 5'h00;
        data1    = 32'd9;
        data2    = 32'd9;
        flush    = 1'b1;
        @(negedge clk);
        checkOutput("flush_no_accept", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        checkOutput("flush_no_result", {63'b0, out_valid}, 64'd0);
        repeat (3) @(posedge clk);
        #1;

        checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised, handshaked execution unit for the rv32i core. It is the successor to the single-cycle combinational ALU: it keeps all ten base integer operations and adds the RV32M multiply/divide group. The M group runs on an iterative shift-add/shift-subtract datapath. The block sits in the execute stage behind a valid/ready interface, so the core stalls on multi-cycle operations without external sequencing.

## Interface
Parameters:
- XLEN, default 32: operand/result width. Must be 32 or 64.
- SHW, default $clog2(XLEN): number of shift-amount bits taken from data2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous abort of in-flight and pending results.
- in_valid, input, 1: op/data1/data2 are valid.
- in_ready, output, 1: block accepts the request this cycle.
- op, input, 5: operation code.
- data1, input, XLEN: operand A (rs1).
- data2, input, XLEN: operand B (rs2 or immediate).
- out_valid, output, 1: result/zero/err are valid.
- out_ready, input, 1: consumer takes the result this cycle.
- result, output, XLEN: registered result.
- zero, output, 1: registered flag, high when result == 0.
- err, output, 1: registered flag, high when op is unsupported.

## Operation
- Opcodes 0x00–0x09 are the base group: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Opcodes 0x10–0x17 are the M group: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Any other code completes as a base op with result 0, zero 0 and err 1.
- Shifts use data2[SHW-1:0]. SRA is arithmetic and replicates data1[XLEN-1]. SLT is signed; SLTU is unsigned. SLT and SLTU return 0 or 1, zero-extended.
- All arithmetic wraps modulo 2^XLEN.
- MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Division by zero: DIV and DIVU return all ones; REM and REMU return data1.
- Signed overflow (data1 = -2^(XLEN-1), data2 = -1): DIV returns data1; REM returns 0.
- Signed DIV and REM run on magnitudes with a sign fix-up. Quotient sign = sign(data1) XOR sign(data2); remainder sign = sign(data1).
- State machine:
  - IDLE: accept a request when in_valid && in_ready.
    - Base op: result is computed combinationally, written to the output register, and the FSM stays in IDLE.
    - M op: operands are latched, the counter is set to XLEN, and the FSM moves to CALC.
  - CALC: one multiply or divide step per cycle and the counter decrements. When the counter reaches 1, the final (sign-corrected) value is written to the output register and the FSM moves to IDLE.
- Output register: one entry. It is loaded as above and holds result/zero/err stable while out_valid && !out_ready. It is cleared when out_valid && out_ready, unless it is reloaded in the same cycle.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush. This allows back-to-back base ops at one per cycle with no bubbles.
- Flush: forces state to IDLE and out_valid to 0, and discards the in-flight M op. in_ready is low during the flush cycle.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 0, err 0, counter 0. in_ready is 1 once rst_n is high and flush is low.
- Latency, for a request accepted in cycle N:
  - Base op or illegal op: out_valid is high in cycle N+1.
  - M op: out_valid is high in cycle N+1+XLEN (N+33 at XLEN = 32).
  - in_ready is low from cycle N+1 through cycle N+XLEN.
- Backpressure: while out_valid && !out_ready, in_ready is 0, the outputs are frozen, and no new request is accepted.
- Drain and accept together: a cycle with out_valid && out_ready && in_valid accepts the new request. For a base op, out_valid stays 1 in the next cycle and carries the new result.
- Reset asserted mid-CALC: immediate asynchronous return to reset values; no partial result is ever presented.
- Flush and in_valid in the same cycle: the request is not accepted.
- Flush and out_ready in the same cycle: the result is dropped; out_valid is 0 in the next cycle.
- Operand inputs are sampled only in the accept cycle; they may change during CALC without effect.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1: out_valid at N+1, result 0x80000000, zero 0. SUB 5 - 5: result 0, zero 1.
- SRA 0x80000000 by data2 = 0x24 (amount 4): result 0xF8000000. SLT -1 < 1: result 1. SLTU with the same operands: result 0.
- MULH 0x80000000 × 0x80000000: in_ready low for 32 cycles, out_valid at N+33, result 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF: result 0xFFFFFFFE.
- DIV 7 / 0: result 0xFFFFFFFF. REM 7 / 0: result 7. DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM of the same operands: result 0, zero 1. DIV -7 / 2: result 0xFFFFFFFD. REM -7 / 2: result 0xFFFFFFFF.
- Back-to-back ADD stream with out_ready toggling 1,0,1: one result per accepted op, outputs held stable while stalled, no drops or duplicates. Opcode 0x0A: err 1, result 0.
- DIVU issued, then flush at cycle N+10: out_valid stays 0 and in_ready returns next cycle. Repeat with rst_n pulsed low at N+10: all outputs at reset values, then a new ADD completes normally.
